// File: rtl/board_buffer_if.sv
// board_buffer_if: display read port and engine write/commit port of the Life board buffer
interface board_buffer_if #(
    parameter int COUNT_W = 16
);
    logic [1:0]         array_pos;
    logic [15:0]        alive;
    logic [15:0]        alive_prev;
    logic               wr_valid;
    logic               wr_ready;
    logic [1:0]         wr_bank;
    logic [15:0]        wr_data;
    logic               gen_done;
    logic               frame_end;
    logic               pending;
    logic [COUNT_W-1:0] gen_count;

    modport master (
        output array_pos, wr_valid, wr_bank, wr_data, gen_done, frame_end,
        input  alive, alive_prev, wr_ready, pending, gen_count
    );

    modport slave (
        input  array_pos, wr_valid, wr_bank, wr_data, gen_done, frame_end,
        output alive, alive_prev, wr_ready, pending, gen_count
    );
endinterface

// File: rtl/board_buffer.sv
// board_buffer: triple-buffered 8x8 Life generation store with tear-free swap at frame end
module board_buffer #(
    parameter logic [63:0] SEED    = 64'h0,
    parameter int          COUNT_W = 16
) (
    input logic          clk,
    input logic          reset,
    board_buffer_if.slave bus
);
    typedef enum logic [1:0] {LOAD, HOLD, SWAP} state_t;

    state_t             state;
    logic [63:0]        cur;
    logic [63:0]        prev;
    logic [63:0]        pend;
    logic [COUNT_W-1:0] cnt;
    logic               wr_ready_q;
    logic               pending_q;

    assign bus.alive      = cur[{bus.array_pos, 4'h0} +: 16];
    assign bus.alive_prev = prev[{bus.array_pos, 4'h0} +: 16];
    assign bus.wr_ready   = wr_ready_q;
    assign bus.pending    = pending_q;
    assign bus.gen_count  = cnt;

    // Load pending banks, hold the commit until frame end, then rotate pend->cur->prev
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= LOAD;
            cur        <= SEED;
            pend       <= SEED;
            prev       <= '0;
            cnt        <= '0;
            wr_ready_q <= 1'b1;
            pending_q  <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (bus.wr_valid && wr_ready_q)
                        pend[{bus.wr_bank, 4'h0} +: 16] <= bus.wr_data;
                    if (bus.gen_done) begin
                        state      <= HOLD;
                        wr_ready_q <= 1'b0;
                        pending_q  <= 1'b1;
                    end
                end
                HOLD: begin
                    if (bus.frame_end)
                        state <= SWAP;
                end
                SWAP: begin
                    prev       <= cur;
                    cur        <= pend;
                    cnt        <= cnt + 1'b1;
                    state      <= LOAD;
                    wr_ready_q <= 1'b1;
                    pending_q  <= 1'b0;
                end
                default: begin
                    state      <= LOAD;
                    wr_ready_q <= 1'b1;
                    pending_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule
